// File: rtl/regfile_wr_ctrl.sv
// Write-back controller: decodes writeback destinations into a registered one-hot
// register-file write enable and keeps a busy scoreboard for issue hazard checks.
module regfile_wr_ctrl #(
  parameter int NREG = 32,
  parameter int AW = 5,
  parameter int DW = 32,
  parameter logic [NREG-1:0] IMPL_MASK = 32'h0FFC0201,
  localparam int CW = $clog2(NREG + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  output logic            iss_ready,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [DW-1:0]   wb_data,
  output logic [NREG-1:0] we_onehot,
  output logic [DW-1:0]   wr_data,
  output logic [NREG-1:0] busy,
  output logic [CW-1:0]   pend_cnt,
  output logic            err_unimpl
);

  logic [NREG-1:0] we_q, we_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   pend_q, pend_d;
  logic            err_q, err_d;
  logic            iss_acc;

  function automatic logic in_range(input logic [AW-1:0] a);
    logic [31:0] a32;
    a32 = 32'(a);
    return a32 < 32'(NREG);
  endfunction

  // x0 is never writable, so bit 0 of the mask is ignored here
  function automatic logic is_impl(input logic [AW-1:0] a);
    return (a != '0) && in_range(a) && IMPL_MASK[a];
  endfunction

  function automatic logic busy_at(input logic [NREG-1:0] b, input logic [AW-1:0] a);
    return in_range(a) ? b[a] : 1'b0;
  endfunction

  assign iss_ready = !(busy_at(busy_q, iss_rs1) | busy_at(busy_q, iss_rs2) |
                       busy_at(busy_q, iss_rd));
  assign iss_acc   = iss_valid && iss_ready;

  always_comb begin
    busy_d    = busy_q;
    we_d      = '0;
    wr_data_d = wr_data_q;
    err_d     = err_q;
    pend_d    = '0;

    if (wb_valid) begin
      wr_data_d = wb_data;
      if (is_impl(wb_rd)) begin
        we_d[wb_rd]   = 1'b1;
        busy_d[wb_rd] = 1'b0;
      end else if (wb_rd != '0) begin
        err_d = 1'b1;
      end
    end

    // Reservation is applied after the clear so a same-register collision stays busy
    if (iss_acc) begin
      if (is_impl(iss_rd)) begin
        busy_d[iss_rd] = 1'b1;
      end else if (iss_rd != '0) begin
        err_d = 1'b1;
      end
    end

    for (int i = 0; i < NREG; i++) begin
      pend_d = pend_d + CW'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q      <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
      pend_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      we_q      <= we_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
    end
  end

  assign we_onehot  = we_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign pend_cnt   = pend_q;
  assign err_unimpl = err_q;

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Directed bench for regfile_wr_ctrl: writeback pulses, scoreboard hazards,
// x0/unimplemented handling, collisions, asynchronous reset and an address sweep.
module tb_regfile_wr_ctrl;

  localparam int NREG = 32;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 6;
  localparam logic [31:0] WMASK = 32'h0FFC0200;

  logic            clk;
  logic            rst;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd, iss_rs1, iss_rs2;
  logic            iss_ready;
  logic            wb_valid;
  logic [AW-1:0]   wb_rd;
  logic [DW-1:0]   wb_data;
  logic [NREG-1:0] we_onehot;
  logic [DW-1:0]   wr_data;
  logic [NREG-1:0] busy;
  logic [CW-1:0]   pend_cnt;
  logic            err_unimpl;

  int n_pass = 0;
  int n_total = 0;

  regfile_wr_ctrl #(.NREG(NREG), .AW(AW), .DW(DW), .IMPL_MASK(32'h0FFC0201)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_ready(iss_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .we_onehot(we_onehot), .wr_data(wr_data), .busy(busy),
    .pend_cnt(pend_cnt), .err_unimpl(err_unimpl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 1'b0;
    wb_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0;
    wb_rd = '0; wb_data = '0;
    tick();
    tick();
    chk("rst_ready", 32'(iss_ready), 32'd1);
    chk("rst_we", we_onehot, 32'h0);
    chk("rst_wrdata", wr_data, 32'h0);
    chk("rst_busy", busy, 32'h0);
    chk("rst_pend", 32'(pend_cnt), 32'd0);
    chk("rst_err", 32'(err_unimpl), 32'd0);
    rst = 1'b0;
    tick();

    // writeback to x9
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'hDEADBEEF;
    tick();
    idle();
    chk("wb9_we", we_onehot, 32'h0000_0200);
    chk("wb9_data", wr_data, 32'hDEADBEEF);
    chk("wb9_err", 32'(err_unimpl), 32'd0);
    tick();
    chk("wb9_pulse_end", we_onehot, 32'h0);
    chk("wb9_data_hold", wr_data, 32'hDEADBEEF);

    // reserve x20, hazard on rs1, then release by writeback
    iss_valid = 1'b1; iss_rd = 5'd20; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
    chk("iss20_ready_before", 32'(iss_ready), 32'd1);
    tick();
    chk("iss20_busy", busy, 32'h0010_0000);
    chk("iss20_pend", 32'(pend_cnt), 32'd1);
    iss_rd = 5'd0; iss_rs1 = 5'd20;
    #1;
    chk("rs1_hazard", 32'(iss_ready), 32'd0);
    tick();
    chk("stall_no_change", busy, 32'h0010_0000);
    wb_valid = 1'b1; wb_rd = 5'd20; wb_data = 32'h0000_1234;
    tick();
    idle();
    chk("wb20_busy", busy, 32'h0);
    chk("wb20_pend", 32'(pend_cnt), 32'd0);
    chk("wb20_ready", 32'(iss_ready), 32'd1);
    chk("wb20_we", we_onehot, 32'h0010_0000);
    chk("wb20_data", wr_data, 32'h0000_1234);
    iss_rs1 = 5'd0;

    // x0 issue and writeback
    iss_valid = 1'b1; iss_rd = 5'd0;
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000_AAAA;
    tick();
    idle();
    chk("x0_we", we_onehot, 32'h0);
    chk("x0_busy", busy, 32'h0);
    chk("x0_err", 32'(err_unimpl), 32'd0);
    chk("x0_data", wr_data, 32'h0000_AAAA);

    // unimplemented writeback sets sticky error
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h5555_5555;
    tick();
    idle();
    chk("wb5_we", we_onehot, 32'h0);
    chk("wb5_err", 32'(err_unimpl), 32'd1);
    repeat (10) tick();
    chk("err_sticky", 32'(err_unimpl), 32'd1);

    // unimplemented issue is accepted without reservation
    iss_valid = 1'b1; iss_rd = 5'd6;
    tick();
    idle();
    chk("iss6_busy", busy, 32'h0);

    // same-register collision: write happens, set wins
    iss_valid = 1'b1; iss_rd = 5'd22;
    wb_valid = 1'b1; wb_rd = 5'd22; wb_data = 32'h2222_2222;
    tick();
    idle();
    chk("col22_we", we_onehot, 32'h0040_0000);
    chk("col22_busy", busy, 32'h0040_0000);
    chk("col22_pend", 32'(pend_cnt), 32'd1);

    // independent issue x23 and writeback x22
    iss_valid = 1'b1; iss_rd = 5'd23;
    wb_valid = 1'b1; wb_rd = 5'd22; wb_data = 32'h3333_3333;
    tick();
    idle();
    chk("ind_we", we_onehot, 32'h0040_0000);
    chk("ind_busy", busy, 32'h0080_0000);
    wb_valid = 1'b1; wb_rd = 5'd23;
    tick();
    idle();
    chk("clr23_busy", busy, 32'h0);

    // reserve x18, x19, x27 then reset mid-pulse
    iss_valid = 1'b1;
    iss_rd = 5'd18; tick();
    iss_rd = 5'd19; tick();
    iss_rd = 5'd27; tick();
    idle();
    chk("res3_busy", busy, 32'h080C_0000);
    chk("res3_pend", 32'(pend_cnt), 32'd3);
    wb_valid = 1'b1; wb_rd = 5'd18; wb_data = 32'h1818_1818;
    tick();
    idle();
    chk("wb18_we", we_onehot, 32'h0004_0000);
    chk("wb18_pend", 32'(pend_cnt), 32'd2);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 32'h0);
    chk("arst_pend", 32'(pend_cnt), 32'd0);
    chk("arst_we", we_onehot, 32'h0);
    chk("arst_err", 32'(err_unimpl), 32'd0);
    chk("arst_data", wr_data, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_we0", we_onehot, 32'h0);
    tick();
    chk("post_rst_we1", we_onehot, 32'h0);

    // back-to-back sweep of every destination
    for (int a = 0; a < 32; a++) begin
      logic [31:0] exp_we;
      exp_we = WMASK[a] ? (32'h1 << a) : 32'h0;
      wb_valid = 1'b1; wb_rd = AW'(a); wb_data = 32'(a) ^ 32'hA5A5_0000;
      tick();
      chk($sformatf("sweep_we_%0d", a), we_onehot, exp_we);
      chk($sformatf("sweep_err_%0d", a), 32'(err_unimpl), (a != 0) ? 32'd1 : 32'd0);
      chk($sformatf("sweep_data_%0d", a), wr_data, 32'(a) ^ 32'hA5A5_0000);
    end
    idle();
    tick();
    chk("sweep_end_we", we_onehot, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_wr_ctrl.md
# regfile_wr_ctrl

- Parametrised write-back controller for the single-cycle RISC-V register file.
- Decodes a writeback destination into a registered one-hot write enable, restricted to a configurable set of implemented registers, with x0 never writable.
- Keeps a busy scoreboard so issue logic can stall on pending destinations and sources.
- Sits between the decode/issue stage and the register file; owns all register-file write enables.

## Interface
Parameters:
- NREG, 32, number of architectural registers
- AW, 5, register address width; must be at least clog2(NREG)
- DW, 32, data width
- IMPL_MASK, 32'h0FFC0201, bit i set = register i implemented (x0, x9, x18–x27); bit 0 is ignored for writes

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- iss_valid  in  1  issue stage presents an instruction
- iss_rd  in  AW  destination to reserve
- iss_rs1  in  AW  source 1 for hazard check
- iss_rs2  in  AW  source 2 for hazard check
- iss_ready  out  1  combinational; issue may proceed
- wb_valid  in  1  writeback request this cycle
- wb_rd  in  AW  writeback destination
- wb_data  in  DW  writeback data
- we_onehot  out  NREG  registered one-hot write enable to the register file
- wr_data  out  DW  registered write data
- busy  out  NREG  scoreboard; bit i = write to register i pending
- pend_cnt  out  clog2(NREG+1)  number of set busy bits
- err_unimpl  out  1  sticky; an unimplemented destination was targeted

## Operation
- Implemented destination: address < NREG, IMPL_MASK bit set, and address != 0.
- iss_ready = !(busy[iss_rs1] | busy[iss_rs2] | busy[iss_rd]). Out-of-range addresses read as not busy. busy[0] is always 0.
- Issue accept: iss_valid && iss_ready.
  - Implemented iss_rd: busy[iss_rd] is set on the next edge.
  - iss_rd = 0: accepted; no reservation and no error.
  - Unimplemented, nonzero iss_rd: accepted; no reservation; err_unimpl set.
- Writeback (wb_valid):
  - Implemented wb_rd: we_onehot = 1 << wb_rd on the next cycle, wr_data = wb_data, busy[wb_rd] cleared.
  - wb_rd = 0: we_onehot = 0; wr_data is still updated.
  - Unimplemented, nonzero wb_rd: we_onehot = 0 and err_unimpl set.
- Writeback to a register that is not busy is legal: the write occurs and no error is flagged.
- Without wb_valid, we_onehot is all zero the next cycle and wr_data holds its value.
- Simultaneous events:
  - Accepted issue and writeback on the same implemented register in the same cycle: the write occurs and busy ends at 1 (set wins).
  - Issue and writeback on different registers are fully independent.
- pend_cnt is a registered popcount of the next busy value and always equals popcount(busy).
- err_unimpl clears only on rst.

## Timing
- Reset values: we_onehot = 0, wr_data = 0, busy = 0, pend_cnt = 0, err_unimpl = 0.
- iss_ready is high during reset.
- Writeback latency is 1 cycle: request in cycle N gives the enable pulse in cycle N+1, one cycle wide per request.
- Back-to-back writebacks produce consecutive one-cycle pulses.
- Scoreboard timing:
  - A set is visible on busy and iss_ready in the cycle after acceptance.
  - A clear is visible in the cycle after wb_valid.
  - iss_ready combinationally reflects the current busy only; there is no same-cycle forwarding.
- Reset asserted mid-operation clears all pending reservations, the pending pulse, and the error immediately (asynchronously). No enable pulse is issued after reset deasserts.
- pend_cnt saturation is impossible: its maximum is popcount(IMPL_MASK) − bit 0.

## Test plan
- Reset, then wb_valid with wb_rd=9, wb_data=32'hDEADBEEF → next cycle we_onehot=32'h00000200, wr_data=DEADBEEF; pulse lasts exactly 1 cycle; err_unimpl=0.
- Issue rd=20 accepted, then issue rs1=20 → iss_ready=0 and busy[20]=1, pend_cnt=1. Then wb_rd=20 → next cycle busy[20]=0, iss_ready=1, we_onehot bit 20 pulses.
- Write or issue to x0 (wb_rd=0, iss_rd=0) → we_onehot=0, busy unchanged, err_unimpl=0. Then wb_rd=5 (unimplemented) → we_onehot=0 and err_unimpl=1, sticky across 10 idle cycles.
- Same cycle: issue rd=22 and wb_rd=22 → we_onehot bit 22 pulses, busy[22]=1, pend_cnt=1.
- Reserve rd=18,19,27, so pend_cnt=3, then assert rst mid-pulse of wb_rd=18 → busy=0, pend_cnt=0, we_onehot=0 immediately; no pulse after release.
- Sweep wb_rd 0–31 → pulses only on bits 9 and 18–27; err_unimpl set exactly after the first unimplemented nonzero address (1).
